// File: rtl/uart_tx_arbiter_if.sv
// Request/serializer bundle between the echo and message front-ends, the
// transmit arbiter and the UART serializer.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  // Valid/ready: a requester raises *_valid with stable data (and msg_last)
  // and holds them until it sees *_ready high for one cycle; it may present
  // the next item on the clock edge that ends that ready cycle.
  logic              echo_valid;
  logic [DATA_W-1:0] echo_data;
  logic              echo_ready;
  logic              msg_valid;
  logic [DATA_W-1:0] msg_data;
  logic              msg_last;
  logic              msg_ready;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;

  modport master (
    input  echo_valid, echo_data, msg_valid, msg_data, msg_last, tx_busy,
    output echo_ready, msg_ready, tx_start, tx_data
  );

  modport slave (
    output echo_valid, echo_data, msg_valid, msg_data, msg_last, tx_busy,
    input  echo_ready, msg_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between echo and message requesters, locking the
// line for whole messages. Define TX_ARB_RR_EN for round-robin arbitration.
module uart_tx_arbiter #(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 10,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SW,
  uart_tx_arbiter_if.master    bus,
  output logic [1:0]           grant,
  output logic                 word_on_line,
  output logic [CNT_W-1:0]     sent_count,
  output logic                 tx_err,
  output logic [2:0]           state_dbg
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_WAIT_ACCEPT = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_HOLD        = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic                last_lat, last_lat_nxt;
  logic                pick_echo, pick_msg, load;
  logic                busy_timeout, byte_done, owner_done;
  logic                tx_start_nxt, echo_ready_nxt, msg_ready_nxt;
  logic [DATA_W-1:0]   tx_data_nxt;
  logic [1:0]          grant_nxt;
  logic                word_on_line_nxt, tx_err_nxt;
  logic [CNT_W-1:0]    sent_count_nxt;
`ifdef TX_ARB_RR_EN
  logic                last_msg, last_msg_nxt;
`endif

  // Requests are only sampled in IDLE and HOLD; HOLD admits the message side only.
  always_comb begin
    pick_echo = 1'b0;
    pick_msg  = 1'b0;
    if (state == S_IDLE) begin
      if (bus.echo_valid && bus.msg_valid && SW) begin
`ifdef TX_ARB_RR_EN
        pick_echo = last_msg;
`else
        pick_echo = 1'b1;
`endif
        pick_msg = ~pick_echo;
      end else begin
        pick_echo = bus.echo_valid;
        pick_msg  = bus.msg_valid & SW;
      end
    end else if (state == S_HOLD) begin
      pick_msg = bus.msg_valid & SW;
    end
  end

  assign load         = pick_echo | pick_msg;
  assign busy_timeout = (state == S_WAIT_ACCEPT) && !bus.tx_busy &&
                        (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));
  assign byte_done    = (state == S_WAIT_DONE) && !bus.tx_busy;
  assign owner_done   = grant[0] | last_lat;
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (load) state_nxt = S_LOAD;
      S_LOAD:        state_nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (bus.tx_busy)       state_nxt = S_WAIT_DONE;
        else if (busy_timeout) state_nxt = S_IDLE;
      end
      S_WAIT_DONE:   if (byte_done) state_nxt = owner_done ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (load)     state_nxt = S_LOAD;
        else if (!SW) state_nxt = S_IDLE;
      end
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Every output is computed here one cycle early and registered below.
  always_comb begin
    tx_start_nxt     = load;
    echo_ready_nxt   = pick_echo;
    msg_ready_nxt    = pick_msg;
    tx_data_nxt      = bus.tx_data;
    grant_nxt        = grant;
    word_on_line_nxt = word_on_line;
    sent_count_nxt   = sent_count;
    tx_err_nxt       = tx_err;
    last_lat_nxt     = last_lat;
    tmo_cnt_nxt      = tmo_cnt;
`ifdef TX_ARB_RR_EN
    last_msg_nxt     = last_msg;
`endif
    if (load) begin
      tx_data_nxt      = pick_echo ? bus.echo_data : bus.msg_data;
      grant_nxt        = {pick_msg, pick_echo};
      word_on_line_nxt = 1'b1;
      last_lat_nxt     = pick_msg & bus.msg_last;
`ifdef TX_ARB_RR_EN
      last_msg_nxt     = pick_msg;
`endif
    end
    if (state == S_LOAD)
      tmo_cnt_nxt = '0;
    else if (state == S_WAIT_ACCEPT && !bus.tx_busy)
      tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    if (busy_timeout) begin
      tx_err_nxt       = 1'b1;
      grant_nxt        = 2'b00;
      word_on_line_nxt = 1'b0;
    end
    if (byte_done) begin
      sent_count_nxt   = sent_count + CNT_W'(1);
      word_on_line_nxt = 1'b0;
      if (owner_done) grant_nxt = 2'b00;
    end
    if (state == S_HOLD && !load && !SW)
      grant_nxt = 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      tmo_cnt        <= '0;
      last_lat       <= 1'b0;
      bus.tx_start   <= 1'b0;
      bus.echo_ready <= 1'b0;
      bus.msg_ready  <= 1'b0;
      bus.tx_data    <= '0;
      grant          <= 2'b00;
      word_on_line   <= 1'b0;
      sent_count     <= '0;
      tx_err         <= 1'b0;
`ifdef TX_ARB_RR_EN
      last_msg       <= 1'b1;
`endif
    end else begin
      state          <= state_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
      last_lat       <= last_lat_nxt;
      bus.tx_start   <= tx_start_nxt;
      bus.echo_ready <= echo_ready_nxt;
      bus.msg_ready  <= msg_ready_nxt;
      bus.tx_data    <= tx_data_nxt;
      grant          <= grant_nxt;
      word_on_line   <= word_on_line_nxt;
      sent_count     <= sent_count_nxt;
      tx_err         <= tx_err_nxt;
`ifdef TX_ARB_RR_EN
      last_msg       <= last_msg_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-fed requesters, a serializer
// model and a scoreboard of expected {grant, byte} per tx_start.
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int CW = 10;
  localparam int BT = 16;

  logic          clk;
  logic          rst;
  logic          sw;
  logic [1:0]    grant;
  logic          wol;
  logic [CW-1:0] sent_count;
  logic          tx_err;
  logic [2:0]    state_dbg;

  uart_tx_arbiter_if #(.DATA_W(DW)) bus ();

  uart_tx_arbiter #(.DATA_W(DW), .CNT_W(CW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .SW(sw), .bus(bus.master), .grant(grant),
    .word_on_line(wol), .sent_count(sent_count), .tx_err(tx_err),
    .state_dbg(state_dbg)
  );

  int            checks = 0;
  int            failures = 0;
  logic [9:0]    exp_q[$];
  logic [DW-1:0] echo_src_q[$];
  logic [DW:0]   msg_src_q[$];
  logic [CW-1:0] exp_count;
  int            echo_rdy_cnt = 0;
  int            msg_rdy_cnt = 0;
  int            busy_cnt;
  int            ser_len = 4;
  bit            ser_en = 1'b1;
  bit            prev_start = 1'b0;
`ifdef TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // serializer model: busy rises the edge after tx_start, lasts ser_len cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) busy_cnt <= 0;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (bus.tx_start && ser_en) busy_cnt <= ser_len;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  // requester drivers
  initial begin
    bus.echo_valid = 1'b0;
    bus.echo_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) bus.echo_valid = 1'b0;
      else begin
        if (bus.echo_valid && bus.echo_ready) begin
          echo_src_q.delete(0);
          bus.echo_valid = 1'b0;
        end
        if (!bus.echo_valid && echo_src_q.size() > 0) begin
          bus.echo_valid = 1'b1;
          bus.echo_data  = echo_src_q[0];
        end
      end
    end
  end

  initial begin
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    bus.msg_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) bus.msg_valid = 1'b0;
      else begin
        if (bus.msg_valid && bus.msg_ready) begin
          msg_src_q.delete(0);
          bus.msg_valid = 1'b0;
        end
        if (!bus.msg_valid && msg_src_q.size() > 0) begin
          bus.msg_valid = 1'b1;
          bus.msg_data  = msg_src_q[0][DW-1:0];
          bus.msg_last  = msg_src_q[0][DW];
        end
      end
    end
  end

  // scoreboard: every tx_start must match the next expected {grant, byte}
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      if (bus.echo_ready) echo_rdy_cnt++;
      if (bus.msg_ready)  msg_rdy_cnt++;
      if (bus.tx_start) begin
        chk("start_pulse_width", {31'd0, prev_start}, 0);
        if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("tx_data", bus.tx_data, e[7:0]);
          chk("grant_at_start", grant, e[9:8]);
          chk("echo_ready_at_start", bus.echo_ready, e[8]);
          chk("msg_ready_at_start", bus.msg_ready, e[9]);
        end
      end
    end
    prev_start = bus.tx_start;
  end

  task automatic chk_reset(input string pfx);
    chk({pfx, "_tx_start"}, bus.tx_start, 0);
    chk({pfx, "_echo_ready"}, bus.echo_ready, 0);
    chk({pfx, "_msg_ready"}, bus.msg_ready, 0);
    chk({pfx, "_tx_data"}, bus.tx_data, 0);
    chk({pfx, "_grant"}, grant, 0);
    chk({pfx, "_wol"}, wol, 0);
    chk({pfx, "_sent_count"}, sent_count, 0);
    chk({pfx, "_tx_err"}, tx_err, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    echo_src_q.delete();
    msg_src_q.delete();
    exp_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b1;
    exp_count = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (echo_src_q.size() == 0 && msg_src_q.size() == 0 && exp_q.size() == 0 &&
          grant == 2'b00 && !wol && !bus.tx_busy && !bus.echo_valid && !bus.msg_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 1);
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 1);
  endtask

  // Reference arbitration: everything pending up front; a message without its
  // last byte locks the line, otherwise fixed priority or alternation decides.
  task automatic model_round(input logic [DW-1:0] e_l[$], input logic [DW:0] m_l[$]);
    bit locked = 1'b0;
    bit last_msg = 1'b1;
    bit take_msg;
    logic [DW:0] m;
    while (e_l.size() + m_l.size() > 0) begin
      if (locked || e_l.size() == 0) take_msg = 1'b1;
      else if (m_l.size() == 0)      take_msg = 1'b0;
      else                           take_msg = RR ? !last_msg : 1'b0;
      if (take_msg) begin
        m = m_l.pop_front();
        exp_q.push_back({2'b10, m[DW-1:0]});
        locked = !m[DW];
        last_msg = 1'b1;
      end else begin
        exp_q.push_back({2'b01, e_l.pop_front()});
        last_msg = 1'b0;
      end
      exp_count = exp_count + 1'b1;
    end
  endtask

  initial begin
    logic [DW-1:0] e_l[$];
    logic [DW:0]   m_l[$];
    int            n, rdy0, ne, nm;
    bit            bad;
    logic [DW-1:0] d;

    rst = 1'b0;
    sw  = 1'b1;
    exp_count = '0;
    repeat (3) @(negedge clk);
    chk_reset("init");
    rst = 1'b1;

    // single echo byte with a 20-cycle serializer
    ser_len = 20;
    rdy0 = echo_rdy_cnt;
    exp_q.push_back({2'b01, 8'h41});
    echo_src_q.push_back(8'h41);
    exp_count = exp_count + 1'b1;
    wait_start("echo_start_seen");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!wol) break;
      n++;
      @(negedge clk);
    end
    chk("echo_wol_cycles", n, ser_len + 2);
    wait_idle("echo_idle", 200);
    chk("echo_sent_count", sent_count, exp_count);
    chk("echo_ready_pulses", echo_rdy_cnt - rdy0, 1);

    // reset asserted while the serializer is busy
    exp_q.push_back({2'b01, 8'h5a});
    echo_src_q.push_back(8'h5a);
    wait_start("midrst_start_seen");
    repeat (6) @(negedge clk);
    chk("midrst_busy_before", bus.tx_busy, 1);
    #2 rst = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_count = '0;
    repeat (3) @(negedge clk);
    chk("midrst_count_after", sent_count, 0);

    // three-byte message with an echo arriving during its first byte
    ser_len = $urandom_range(3, 8);
    exp_q.push_back({2'b10, 8'h48});
    exp_q.push_back({2'b10, 8'h69});
    exp_q.push_back({2'b10, 8'h21});
    exp_q.push_back({2'b01, 8'h41});
    msg_src_q.push_back({1'b0, 8'h48});
    msg_src_q.push_back({1'b0, 8'h69});
    msg_src_q.push_back({1'b1, 8'h21});
    rdy0 = msg_rdy_cnt;
    wait_start("msg_start_seen");
    echo_src_q.push_back(8'h41);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (grant !== 2'b10) bad = 1'b1;
      @(negedge clk);
      if (msg_rdy_cnt - rdy0 == 3 && !wol) break;
    end
    chk("msg_lock_grant", {31'd0, bad}, 0);
    exp_count = exp_count + 3'd4;
    wait_idle("msg_idle", 200);
    chk("msg_sent_count", sent_count, exp_count);

    // two echoes and two single-byte messages pending together from IDLE
    apply_reset();
    ser_len = 3;
    e_l = {};
    m_l = {};
    for (int i = 0; i < 2; i++) begin
      e_l.push_back(DW'($urandom_range(0, 255)));
      m_l.push_back({1'b1, DW'($urandom_range(0, 255))});
    end
    model_round(e_l, m_l);
    foreach (e_l[i]) echo_src_q.push_back(e_l[i]);
    foreach (m_l[i]) msg_src_q.push_back(m_l[i]);
    wait_idle("arb_idle", 400);
    chk("arb_sent_count", sent_count, exp_count);

    // random mix including multi-byte messages
    apply_reset();
    ser_len = $urandom_range(1, 6);
    e_l = {};
    m_l = {};
    ne = $urandom_range(1, 4);
    nm = $urandom_range(1, 5);
    for (int i = 0; i < ne; i++) e_l.push_back(DW'($urandom_range(0, 255)));
    for (int i = 0; i < nm; i++)
      m_l.push_back({(i == nm - 1) ? 1'b1 : 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255))});
    model_round(e_l, m_l);
    foreach (e_l[i]) echo_src_q.push_back(e_l[i]);
    foreach (m_l[i]) msg_src_q.push_back(m_l[i]);
    wait_idle("mix_idle", 600);
    chk("mix_sent_count", sent_count, exp_count);

    // serializer never answers: timeout sets the sticky error
    ser_en = 1'b0;
    d = DW'($urandom_range(0, 255));
    exp_q.push_back({2'b01, d});
    echo_src_q.push_back(d);
    wait_start("tmo_start_seen");
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (tx_err) break;
    end
    chk("tmo_latency", n, BT + 1);
    chk("tmo_grant", grant, 0);
    chk("tmo_count_unchanged", sent_count, exp_count);
    ser_en = 1'b1;
    d = DW'($urandom_range(0, 255));
    exp_q.push_back({2'b01, d});
    echo_src_q.push_back(d);
    exp_count = exp_count + 1'b1;
    wait_idle("tmo_recover_idle", 200);
    chk("tmo_err_sticky", tx_err, 1);
    chk("tmo_recover_count", sent_count, exp_count);

    // 1024 echo bytes wrap the counter
    apply_reset();
    ser_len = 1;
    for (int i = 0; i < 1024; i++) begin
      d = DW'($urandom_range(0, 255));
      exp_q.push_back({2'b01, d});
      echo_src_q.push_back(d);
      exp_count = exp_count + 1'b1;
    end
    wait_idle("wrap_idle", 20000);
    chk("wrap_sent_count", sent_count, exp_count);
    chk("wrap_count_zero", sent_count, 0);

    // SW=0 masks message requests
    ser_len = $urandom_range(2, 5);
    sw = 1'b0;
    rdy0 = msg_rdy_cnt;
    d = DW'($urandom_range(0, 255));
    msg_src_q.push_back({1'b1, d});
    repeat (10) @(negedge clk);
    chk("sw_mask_no_ready", msg_rdy_cnt - rdy0, 0);
    exp_q.push_back({2'b10, d});
    exp_count = exp_count + 1'b1;
    sw = 1'b1;
    wait_idle("sw_mask_idle", 200);
    chk("sw_mask_count", sent_count, exp_count);

    // HOLD ignores echo; dropping SW abandons the lock and serves the echo
    rdy0 = msg_rdy_cnt;
    d = DW'($urandom_range(0, 255));
    exp_q.push_back({2'b10, d});
    msg_src_q.push_back({1'b0, d});
    exp_count = exp_count + 1'b1;
    bad = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (msg_rdy_cnt - rdy0 == 1 && !wol && !bus.tx_busy) begin
        bad = 1'b0;
        break;
      end
    end
    chk("hold_reached", {31'd0, bad}, 0);
    rdy0 = echo_rdy_cnt;
    d = DW'($urandom_range(0, 255));
    echo_src_q.push_back(d);
    repeat (6) @(negedge clk);
    chk("hold_grant", grant, 2'b10);
    chk("hold_ignores_echo", echo_rdy_cnt - rdy0, 0);
    exp_q.push_back({2'b01, d});
    exp_count = exp_count + 1'b1;
    sw = 1'b0;
    wait_idle("hold_drop_idle", 200);
    chk("hold_drop_count", sent_count, exp_count);
    chk("hold_drop_echo_served", echo_rdy_cnt - rdy0, 1);
    sw = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
